mem_stage_port: RTL
===================

Name: mem_stage_port

Overview:
- CPU-side initiator of the data-memory interface: M-stage store encoder, M/W pipeline register, and W-stage load decoder.
- Drives the byte-enabled DM port (m_data_addr/wdata/byteen, m_inst_addr) and the GRF write-back/trace port (w_grf_*, w_inst_addr) that the bench memory model and trace logger consume.
- Detects misaligned and out-of-range accesses and suppresses their side effects.

Parameters:
- DM_BYTES, 16384: DM size in bytes; legal addresses are 0 to DM_BYTES-1.
- PC_RESET, 32'h0000_3000: value loaded into w_inst_addr on reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_valid  in  1  M-stage instruction present (0 = bubble)
- m_pc  in  32  M-stage instruction PC
- m_op  in  4  memory op code (mem_pkg)
- m_addr  in  32  effective address (ALU result)
- m_store_data  in  32  forwarded rt value
- m_result  in  32  non-load write-back value (ALU or link)
- m_reg_we  in  1  instruction writes GRF
- m_rd  in  5  destination register
- m_data_addr  out  32  DM address
- m_data_wdata  out  32  lane-aligned store data
- m_data_byteen  out  4  byte write enables
- m_data_rdata  in  32  DM read word (combinational from m_data_addr)
- m_inst_addr  out  32  PC of the access (equals m_pc)
- m_exc  out  1  address exception this cycle
- m_exc_code  out  5  4 = AdEL (load), 5 = AdES (store), 0 = none
- w_grf_we  out  1  GRF write enable
- w_grf_addr  out  5  GRF destination
- w_grf_wdata  out  32  GRF write data
- w_inst_addr  out  32  W-stage PC

Behaviour:
- M stage (combinational):
  - m_data_addr = m_addr.
  - m_inst_addr = m_pc.
  - off = m_addr[1:0].
- Misalignment:
  - LW/SW: off != 0.
  - LH/LHU/SH: off[0] = 1.
- Range error: m_addr >= DM_BYTES.
- Exception: m_exc = m_valid and memory op and (misaligned or range error).
  - Code 4 for loads, 5 for stores.
- Byte enables:
  - Forced to 4'b0000 when reset, m_valid = 0, m_exc = 1, or op is not a store.
  - SW: 4'b1111.
  - SH: 4'b0011 shifted left by off.
  - SB: 4'b0001 shifted left by off.
- Store data: SW passes m_store_data through. SH/SB shift the low halfword/byte to the addressed lane; all non-enabled lanes are zero.
- M/W register (posedge clk):
  - Captures m_valid & ~m_exc, m_reg_we, m_rd, m_pc, m_op, off, m_result, and m_data_rdata.
  - Load data is sampled in M; DM is not re-read in W.
- Latency: an instruction in M at cycle t appears on w_* during cycle t+1.
- W stage (combinational decode of registered fields):
  - LW: the full word.
  - LH: sign-extend word[16*off[1] +: 16].
  - LHU: zero-extend word[16*off[1] +: 16].
  - LB: sign-extend word[8*off +: 8].
  - LBU: zero-extend word[8*off +: 8].
  - Any other op: registered m_result.
- w_grf_we = registered valid & reg_we & (rd != 0). A write to $0 never asserts we.
- w_grf_addr and w_grf_wdata are driven even when we = 0. Only we is qualified.
- Reset (synchronous): clears registered valid/we/rd/op/data to 0 and loads w_inst_addr = PC_RESET. Consequences:
  - w_grf_we = 0 in the cycle after reset is sampled.
  - m_data_byteen = 0 for the whole duration of reset.
- Reset mid-access: a store presented in the same cycle as reset is dropped (byteen 0), and the load in flight never reaches W.
- Excepted instruction: the register still captures PC, so w_inst_addr advances, but valid = 0 and no write occurs.
- No stall input: W never stalls. Upstream stalls are presented as m_valid = 0.

Decomposition:
- mem_pkg holds:
  - op codes: MEM_NONE = 0, LW = 1, LH = 2, LHU = 3, LB = 4, LBU = 5, SW = 6, SH = 7, SB = 8;
  - EXC_ADEL = 4, EXC_ADES = 5;
  - helper constants is_load and is_store.
- One sub-module, load_extender: combinational word + off + op to 32-bit write-back value. It is instantiated in W.

Test Plan:
- SB: m_addr = 0x5, m_store_data = 0x12345678 -> byteen = 4'b0010, wdata = 0x00007800, m_exc = 0. Next cycle w_grf_we = 0.
- SH then LH:
  - SH at 0x6 with 0x0000_8001 -> byteen = 4'b1100, wdata = 0x80010000.
  - Next cycle LH at 0x6 with rdata = 0x8001_0000, rd = 8 -> one cycle later w_grf_we = 1, w_grf_addr = 8, w_grf_wdata = 0xFFFF8001, w_inst_addr = that PC.
  - LHU on the same data -> 0x00008001.
- LBU/LB with rdata = 0xA1B2C3D4:
  - LBU at off 2 -> 0x000000B2.
  - LB at off 3 -> 0xFFFFFFA1.
  - LW at 0x0 -> 0xA1B2C3D4.
- Misaligned and out-of-range:
  - SW at 0x2 -> m_exc = 1, code 5, byteen = 0.
  - LW at 0x1 -> code 4, then w_grf_we = 0.
  - LW at 0x4000 with DM_BYTES = 16384 -> code 4.
- $0 and bubble: ALU op with rd = 0, m_result = 0xDEADBEEF -> w_grf_we = 0. With m_valid = 0 and an SW op -> byteen = 0.
- Reset mid-access: assert reset in the cycle an SW and a loading LW are presented -> byteen = 0 that cycle. Next cycle w_grf_we = 0, w_inst_addr = 0x00003000.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared memory-op encodings and helpers for the data-memory port of the CPU.
// Op codes match the M-stage m_op field produced by the decoder.
package mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LW       = 4'd1,
        LH       = 4'd2,
        LHU      = 4'd3,
        LB       = 4'd4,
        LBU      = 4'd5,
        SW       = 4'd6,
        SH       = 4'd7,
        SB       = 4'd8
    } mem_op_e;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    // Registered M/W fields; load data is sampled in M so W never re-reads DM.
    typedef struct packed {
        logic        valid;
        logic        reg_we;
        logic [4:0]  rd;
        logic [31:0] pc;
        mem_op_e     op;
        logic [1:0]  off;
        logic [31:0] result;
        logic [31:0] rdata;
    } mw_reg_t;

    function automatic logic is_load(input mem_op_e op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_store(input mem_op_e op);
        return (op == SW) || (op == SH) || (op == SB);
    endfunction

    // Word ops need off == 0; halfword ops need an even address.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            LW, SW:      mis = (off != 2'b00);
            LH, LHU, SH: mis = off[0];
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_port_if.sv
// Data-memory bus plus GRF write-back/trace port driven by mem_stage_port.
// master = CPU side (mem_stage_port), slave = memory model / trace logger.
interface mem_stage_port_if;

    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_rdata;
    logic [31:0] m_inst_addr;

    logic        w_grf_we;
    logic [4:0]  w_grf_addr;
    logic [31:0] w_grf_wdata;
    logic [31:0] w_inst_addr;

    modport master (
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        input  m_data_rdata,
        output m_inst_addr,
        output w_grf_we,
        output w_grf_addr,
        output w_grf_wdata,
        output w_inst_addr
    );

    modport slave (
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        output m_data_rdata,
        input  m_inst_addr,
        input  w_grf_we,
        input  w_grf_addr,
        input  w_grf_wdata,
        input  w_inst_addr
    );

endinterface

// File: rtl/load_extender.sv
// W-stage load decoder: picks the addressed lane of the sampled DM word and
// sign/zero-extends it; non-load ops pass the registered ALU/link result.
module load_extender
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  mem_op_e     op,
    input  logic [31:0] result,
    output logic [31:0] value
);

    logic [15:0] half;
    logic [7:0]  byte_sel;

    always_comb begin
        half = off[1] ? word[31:16] : word[15:0];
        case (off)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
    end

    always_comb begin
        value = result;
        case (op)
            LW:      value = word;
            LH:      value = {{16{half[15]}}, half};
            LHU:     value = {16'h0000, half};
            LB:      value = {{24{byte_sel[7]}}, byte_sel};
            LBU:     value = {24'h000000, byte_sel};
            default: value = result;
        endcase
    end

endmodule

// File: rtl/mem_stage_port.sv
// CPU-side data-memory initiator: M-stage store encoder and address checks,
// M/W pipeline register, and W-stage load decode onto the GRF write port.
module mem_stage_port
    import mem_pkg::*;
#(
    parameter int          DM_BYTES = 16384,
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,

    // m_valid = 0 is a bubble (also how upstream stalls appear); there is no
    // ready/stall back-pressure: every presented instruction advances to W.
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic [3:0]  m_op,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_store_data,
    input  logic [31:0] m_result,
    input  logic        m_reg_we,
    input  logic [4:0]  m_rd,

    output logic        m_exc,
    output logic [4:0]  m_exc_code,

    mem_stage_port_if.master bus
);

    mem_op_e     op_m;
    logic [1:0]  off_m;
    logic        load_m;
    logic        store_m;
    logic        misaligned_m;
    logic        range_err_m;
    logic        store_ok_m;

    assign op_m         = mem_op_e'(m_op);
    assign off_m        = m_addr[1:0];
    assign load_m       = is_load(op_m);
    assign store_m      = is_store(op_m);
    assign misaligned_m = is_misaligned(op_m, off_m);
    assign range_err_m  = (m_addr >= 32'(DM_BYTES));

    assign m_exc      = m_valid & (load_m | store_m) & (misaligned_m | range_err_m);
    assign m_exc_code = !m_exc  ? EXC_NONE :
                        store_m ? EXC_ADES : EXC_ADEL;

    assign bus.m_data_addr = m_addr;
    assign bus.m_inst_addr = m_pc;

    // Reset, bubbles and excepted stores must never reach memory.
    assign store_ok_m = ~reset & m_valid & ~m_exc & store_m;

    always_comb begin
        bus.m_data_byteen = 4'b0000;
        bus.m_data_wdata  = 32'h0000_0000;
        if (store_ok_m) begin
            case (op_m)
                SW: begin
                    bus.m_data_byteen = 4'b1111;
                    bus.m_data_wdata  = m_store_data;
                end
                SH: begin
                    bus.m_data_byteen = 4'b0011 << off_m;
                    bus.m_data_wdata  = {16'h0000, m_store_data[15:0]} << {off_m, 3'b000};
                end
                SB: begin
                    bus.m_data_byteen = 4'b0001 << off_m;
                    bus.m_data_wdata  = {24'h000000, m_store_data[7:0]} << {off_m, 3'b000};
                end
                default: begin
                    bus.m_data_byteen = 4'b0000;
                    bus.m_data_wdata  = 32'h0000_0000;
                end
            endcase
        end
    end

    mw_reg_t mw_q;

    // PC is captured even for excepted instructions so the trace still advances.
    always_ff @(posedge clk) begin
        if (reset) begin
            mw_q.valid  <= 1'b0;
            mw_q.reg_we <= 1'b0;
            mw_q.rd     <= 5'd0;
            mw_q.pc     <= PC_RESET;
            mw_q.op     <= MEM_NONE;
            mw_q.off    <= 2'd0;
            mw_q.result <= 32'h0000_0000;
            mw_q.rdata  <= 32'h0000_0000;
        end else begin
            mw_q.valid  <= m_valid & ~m_exc;
            mw_q.reg_we <= m_reg_we;
            mw_q.rd     <= m_rd;
            mw_q.pc     <= m_pc;
            mw_q.op     <= op_m;
            mw_q.off    <= off_m;
            mw_q.result <= m_result;
            mw_q.rdata  <= bus.m_data_rdata;
        end
    end

    logic [31:0] wb_value;

    load_extender u_load_extender (
        .word   (mw_q.rdata),
        .off    (mw_q.off),
        .op     (mw_q.op),
        .result (mw_q.result),
        .value  (wb_value)
    );

    // Only we is qualified; addr/data are always driven for the trace logger.
    assign bus.w_grf_we    = mw_q.valid & mw_q.reg_we & (mw_q.rd != 5'd0);
    assign bus.w_grf_addr  = mw_q.rd;
    assign bus.w_grf_wdata = wb_value;
    assign bus.w_inst_addr = mw_q.pc;

endmodule
